// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control/status bundle between the multicycle sequencer and its datapath.
interface cpu_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      ir;
    logic             alu_zero;
    logic             mem_ready;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic             halted;
    logic             illegal;
    logic             bus_err;
    logic [CNT_W-1:0] retired;

    modport master (
        input  ir, alu_zero, mem_ready,
        output ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               reg_write, reg_dst, mem_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               state, halted, illegal, bus_err, retired
    );

    modport slave (
        output ir, alu_zero, mem_ready,
        input  ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               reg_write, reg_dst, mem_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               state, halted, illegal, bus_err, retired
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle MIPS-subset control FSM with memory wait timeout and retire counter.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input logic              clk,
    input logic              rst_n,
    cpu_sequencer_if.master  bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1) < 1 ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TO = CW'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4,
        MEM_WR = 4'd5, EXEC_R = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
        EXEC_I = 4'd10, I_WB = 4'd11, HALT = 4'd12
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             halted_q, halted_d, illegal_q, illegal_d, bus_err_q, bus_err_d;
    logic             ir_write_c, pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c, mem_write_c;
    logic             reg_write_c, reg_dst_c, mem_reg_c, alu_src_a_c;
    logic [1:0]       alu_src_b_c, pc_source_c;
    logic [2:0]       alu_op_c;
    logic             waiting, timeout, unused_ok;
    logic [5:0]       op, funct;

    assign op        = bus.ir[31:26];
    assign funct     = bus.ir[5:0];
    assign unused_ok = ^{bus.ir[25:6], bus.alu_zero};
    assign waiting   = state_q inside {FETCH, MEM_RD, MEM_WR};
    assign timeout   = waiting && !bus.mem_ready && cnt_q == TO;

    always_comb begin
        state_d         = state_q;
        halted_d        = halted_q;
        illegal_d       = illegal_q;
        bus_err_d       = bus_err_q;
        ir_write_c      = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        i_or_d_c        = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        reg_write_c     = 1'b0;
        reg_dst_c       = 1'b0;
        mem_reg_c       = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'b00;
        alu_op_c        = 3'd0;
        pc_source_c     = 2'b00;
        case (state_q)
            FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = bus.mem_ready;
                pc_write_c  = bus.mem_ready;
                state_d     = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b_c = 2'b11;
                if (op == 6'h23 || op == 6'h2b) state_d = MEM_ADDR;
                else if (op == 6'h00 && (funct == 6'h20 || funct == 6'h2a)) state_d = EXEC_R;
                else if (op == 6'h04) state_d = BRANCH;
                else if (op == 6'h08) state_d = EXEC_I;
                else if (op == 6'h02) state_d = JUMP;
                else begin
                    state_d   = HALT;
                    halted_d  = 1'b1;
                    illegal_d = op != 6'h3f;
                end
            end
            MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = op == 6'h23 ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
                state_d    = bus.mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                reg_write_c = 1'b1;
                mem_reg_c   = 1'b1;
                state_d     = FETCH;
            end
            MEM_WR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                state_d     = bus.mem_ready ? FETCH : MEM_WR;
            end
            EXEC_R: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = funct == 6'h2a ? 3'd4 : 3'd0;
                state_d     = R_WB;
            end
            R_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_a_c     = 1'b1;
                alu_op_c        = 3'd6;
                pc_write_cond_c = 1'b1;
                pc_source_c     = 2'b01;
                state_d         = FETCH;
            end
            JUMP: begin
                pc_write_c  = 1'b1;
                pc_source_c = 2'b10;
                state_d     = FETCH;
            end
            EXEC_I: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = I_WB;
            end
            I_WB: begin
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            default: state_d = HALT;
        endcase
        // A stalled access that reaches the limit aborts: ready=0 means no load strobe fired anyway
        if (timeout) begin
            state_d   = HALT;
            bus_err_d = 1'b1;
            halted_d  = 1'b1;
        end
    end

    assign cnt_d     = (waiting && !bus.mem_ready && !timeout) ? cnt_q + 1'b1 : '0;
    assign retired_d = (state_q != FETCH && state_d == FETCH) ? retired_q + 1'b1 : retired_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus.ir_write      = rst_n & ir_write_c;
    assign bus.pc_write      = rst_n & pc_write_c;
    assign bus.pc_write_cond = rst_n & pc_write_cond_c;
    assign bus.i_or_d        = rst_n & i_or_d_c;
    assign bus.mem_read      = rst_n & mem_read_c;
    assign bus.mem_write     = rst_n & mem_write_c;
    assign bus.reg_write     = rst_n & reg_write_c;
    assign bus.reg_dst       = rst_n & reg_dst_c;
    assign bus.mem_reg       = rst_n & mem_reg_c;
    assign bus.alu_src_a     = rst_n & alu_src_a_c;
    assign bus.alu_src_b     = rst_n ? alu_src_b_c : 2'b00;
    assign bus.alu_op        = rst_n ? alu_op_c : 3'd0;
    assign bus.pc_source     = rst_n ? pc_source_c : 2'b00;
    assign bus.state         = state_q;
    assign bus.halted        = halted_q;
    assign bus.illegal       = illegal_q;
    assign bus.bus_err       = bus_err_q;
    assign bus.retired       = retired_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed scoreboard bench; dut1 uses the default timeout, dut2 a timeout of 2.
module tb_cpu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, rst2_n, alu_zero, mem_ready;
    logic [31:0] ir;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    cpu_sequencer_if #(.CNT_W(32)) b1 ();
    cpu_sequencer_if #(.CNT_W(32)) b2 ();
    assign b1.ir = ir;
    assign b1.alu_zero = alu_zero;
    assign b1.mem_ready = mem_ready;
    assign b2.ir = ir;
    assign b2.alu_zero = alu_zero;
    assign b2.mem_ready = mem_ready;

    cpu_sequencer #(.MEM_TIMEOUT(255), .CNT_W(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));
    cpu_sequencer #(.MEM_TIMEOUT(2), .CNT_W(32)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(b2.master));

    typedef struct {
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] sv;
    } exp_t;
    exp_t sb[$];

    // Reference strobe table: {ir_write,pc_write,pc_write_cond,i_or_d,mem_read,mem_write,
    // reg_write,reg_dst,mem_reg,alu_src_a,alu_src_b,alu_op,pc_source}
    function automatic logic [16:0] exp_sv(logic [3:0] s, logic [5:0] f, logic r);
        logic iw, pw, pwc, iod, mr, mw, rw, rd, mreg, asa;
        logic [1:0] asb, ps;
        logic [2:0] aop;
        {iw, pw, pwc, iod, mr, mw, rw, rd, mreg, asa, asb, aop, ps} = '0;
        case (s)
            4'd0:  begin mr = 1; asb = 2'b01; iw = r; pw = r; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mr = 1; iod = 1; end
            4'd4:  begin rw = 1; mreg = 1; end
            4'd5:  begin mw = 1; iod = 1; end
            4'd6:  begin asa = 1; aop = (f == 6'h2a) ? 3'd4 : 3'd0; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; aop = 3'd6; pwc = 1; ps = 2'b01; end
            4'd9:  begin pw = 1; ps = 2'b10; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: rw = 1;
            default: ;
        endcase
        return {iw, pw, pwc, iod, mr, mw, rw, rd, mreg, asa, asb, aop, ps};
    endfunction

    function automatic logic [20:0] obs(bit sel);
        return sel ? {b2.state, b2.ir_write, b2.pc_write, b2.pc_write_cond, b2.i_or_d, b2.mem_read,
                      b2.mem_write, b2.reg_write, b2.reg_dst, b2.mem_reg, b2.alu_src_a, b2.alu_src_b,
                      b2.alu_op, b2.pc_source}
                   : {b1.state, b1.ir_write, b1.pc_write, b1.pc_write_cond, b1.i_or_d, b1.mem_read,
                      b1.mem_write, b1.reg_write, b1.reg_dst, b1.mem_reg, b1.alu_src_a, b1.alu_src_b,
                      b1.alu_op, b1.pc_source};
    endfunction

    task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic push(logic [3:0] s, logic r);
        sb.push_back('{r, s, exp_sv(s, ir[5:0], r)});
    endtask

    task automatic drain(string tag, bit sel);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.rdy;
            #1;
            chk(tag, 64'(obs(sel)), 64'({e.st, e.sv}));
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 0; rst2_n = 0; alu_zero = 0; mem_ready = 1; ir = 32'h8C220004;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_strobes", 64'(obs(0)), 64'({4'd0, 17'd0}));
        chk("rst_flags", {b1.halted, b1.illegal, b1.bus_err}, 3'b000);
        chk("rst_retired", b1.retired, 0);
        @(negedge clk);
        rst_n = 1;
        push(0, 0); push(0, 1); push(1, 1); push(2, 1); push(3, 0); push(3, 1); push(4, 1);
        drain("lw", 0);
        chk("lw_retired", b1.retired, 1);
        ir = 32'h00430820;
        push(0, 1); push(1, 1); push(6, 1); push(7, 1);
        drain("add", 0);
        ir = 32'h0043082A;
        push(0, 1); push(1, 1); push(6, 1); push(7, 1);
        drain("slt", 0);
        chk("r_retired", b1.retired, 3);
        ir = 32'h10220003; alu_zero = 1;
        push(0, 1); push(1, 1); push(8, 1);
        drain("beq_taken", 0);
        alu_zero = 0;
        push(0, 1); push(1, 1); push(8, 1);
        drain("beq_not_taken", 0);
        chk("beq_retired", b1.retired, 5);
        ir = 32'h20220005;
        push(0, 1); push(1, 1); push(10, 1); push(11, 1);
        drain("addi", 0);
        ir = 32'h08000010;
        push(0, 1); push(1, 1); push(9, 1);
        drain("j", 0);
        chk("ij_retired", b1.retired, 7);
        ir = 32'hAC220008;
        push(0, 1); push(1, 1); push(2, 1); push(5, 0); push(5, 0); push(5, 0); push(5, 1);
        drain("sw_wait", 0);
        chk("sw_retired", b1.retired, 8);
        chk("sw_flags", {b1.halted, b1.illegal, b1.bus_err}, 3'b000);
        push(0, 1); push(1, 1); push(2, 1); push(5, 0);
        drain("sw_pre_rst", 0);
        rst_n = 0; mem_ready = 0; #1;
        chk("rst_mid_strobes", 64'(obs(0)), 64'({4'd5, 17'd0}));
        @(negedge clk);
        rst_n = 1; mem_ready = 1; #1;
        chk("post_rst_fetch", 64'(obs(0)), 64'({4'd0, exp_sv(4'd0, ir[5:0], 1'b1)}));
        chk("post_rst_retired", b1.retired, 0);
        @(negedge clk);
        rst_n = 0; rst2_n = 0;
        @(negedge clk);
        rst_n = 1; rst2_n = 1;
        push(0, 1); push(1, 1); push(2, 1); push(5, 0); push(5, 0); push(5, 0);
        push(12, 0); push(12, 1); push(12, 1);
        drain("sw_timeout", 1);
        chk("timeout_flags", {b2.halted, b2.illegal, b2.bus_err}, 3'b101);
        chk("timeout_retired", b2.retired, 0);
        rst_n = 0; rst2_n = 0; mem_ready = 1;
        @(negedge clk);
        rst_n = 1;
        ir = 32'hFC000000;
        push(0, 1); push(1, 1);
        for (int i = 0; i < 11; i++) push(12, 1);
        drain("halt", 0);
        chk("halt_flags", {b1.halted, b1.illegal, b1.bus_err}, 3'b100);
        chk("halt_retired", b1.retired, 0);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        ir = 32'h00000000;
        push(0, 1); push(1, 1);
        for (int i = 0; i < 11; i++) push(12, 1);
        drain("illegal", 0);
        chk("illegal_flags", {b1.halted, b1.illegal, b1.bus_err}, 3'b110);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
